// File: rtl/fread_arbiter.sv
// fread_arbiter: round-robin sharing of one fread request/response channel among NCLI clients.
// One transaction in flight; response bytes are steered to the granted client until RESP_LEN bytes or a watchdog abort.
module fread_arbiter #(
    parameter int NCLI     = 2,
    parameter int RESP_LEN = 2048,
    parameter int TIMEOUT  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCLI-1:0]      cli_req_valid,
    input  logic [32*NCLI-1:0]   cli_req_offset,
    output logic [NCLI-1:0]      cli_req_ready,
    output logic [7:0]           cli_resp_data,
    output logic [NCLI-1:0]      cli_resp_valid,
    output logic                 up_req_valid,
    input  logic                 up_req_ready,
    output logic [31:0]          up_req_offset,
    input  logic [7:0]           up_resp_data,
    input  logic                 up_resp_valid,
    output logic [NCLI-1:0]      grant,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int PW = $clog2(NCLI);
    localparam int CW = $clog2(RESP_LEN + 1);
    localparam int TW = TIMEOUT == 0 ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, state_next;

    logic [PW-1:0]     ptr, owner, pick, winner;
    logic [PW:0]       sum;
    logic [2*NCLI-1:0] rot;
    logic [NCLI-1:0]   win_oh;
    logic [31:0]       win_off;
    logic [CW-1:0]     count;
    logic [TW-1:0]     timer;
    logic              expired, done;

    assign busy           = state != IDLE;
    assign cli_resp_data  = up_resp_data;
    assign cli_resp_valid = state == RESP ? {NCLI{up_resp_valid}} & grant : '0;

    always_comb begin
        // rotate so bit 0 is the client at the pointer; lowest set bit wins
        rot  = {cli_req_valid, cli_req_valid} >> ptr;
        pick = '0;
        for (int i = NCLI - 1; i >= 0; i--)
            if (rot[i]) pick = PW'(i);
        sum     = {1'b0, ptr} + {1'b0, pick};
        winner  = sum >= (PW+1)'(NCLI) ? PW'(sum - (PW+1)'(NCLI)) : PW'(sum);
        win_oh  = NCLI'(1) << winner;
        win_off = '0;
        for (int i = 0; i < NCLI; i++)
            if (PW'(i) == winner) win_off = cli_req_offset[i*32 +: 32];
        expired    = state == RESP && !up_resp_valid && TIMEOUT != 0 && timer == TW'(TIMEOUT - 1);
        done       = expired || (state == RESP && up_resp_valid && count == CW'(RESP_LEN - 1));
        state_next = state == IDLE ? (|cli_req_valid ? REQ : IDLE) :
                     state == REQ  ? (up_req_ready ? RESP : REQ) :
                     done          ? IDLE : RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            grant         <= '0;
            cli_req_ready <= '0;
            up_req_valid  <= 1'b0;
            up_req_offset <= '0;
            count         <= '0;
            timer         <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_next;
            cli_req_ready <= '0;
            if (state == IDLE && |cli_req_valid) begin
                owner         <= winner;
                grant         <= win_oh;
                cli_req_ready <= win_oh;
                up_req_valid  <= 1'b1;
                up_req_offset <= win_off;
            end
            if (state == REQ && up_req_ready) begin
                up_req_valid <= 1'b0;
                count        <= '0;
                timer        <= '0;
            end
            if (state == RESP) begin
                count <= up_resp_valid ? count + 1'b1 : count;
                timer <= up_resp_valid ? '0 : timer + 1'b1;
            end
            if (expired) timeout_err <= 1'b1;
            if (done) begin
                grant <= '0;
                ptr   <= owner == PW'(NCLI - 1) ? '0 : owner + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fread_arbiter.sv
// tb_fread_arbiter: directed transactions with a scoreboard of expected ready pulses and routed bytes.
module tb_fread_arbiter;
    localparam int NCLI = 2, RESP_LEN = 16, TIMEOUT = 100;

    logic clk = 0, rst = 1;
    logic [NCLI-1:0] cli_req_valid = '0, cli_req_ready, cli_resp_valid, grant;
    logic [32*NCLI-1:0] cli_req_offset = '0;
    logic [7:0] cli_resp_data, up_resp_data = '0;
    logic up_req_valid, up_req_ready = 0, up_resp_valid = 0, busy, timeout_err;
    logic [31:0] up_req_offset;
    logic tied = 0;
    int errors = 0, checks = 0;
    logic [NCLI+31:0] ready_q[$];
    logic [NCLI+7:0]  resp_q[$];

    fread_arbiter #(.NCLI(NCLI), .RESP_LEN(RESP_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cli_req_valid(cli_req_valid), .cli_req_offset(cli_req_offset), .cli_req_ready(cli_req_ready),
        .cli_resp_data(cli_resp_data), .cli_resp_valid(cli_resp_valid),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_offset(up_req_offset),
        .up_resp_data(up_resp_data), .up_resp_valid(up_resp_valid),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_off(int c, logic [31:0] v);
        cli_req_offset[c*32 +: 32] = v;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_cli_req_ready"}, cli_req_ready, 0);
        check({tag, "_up_req_valid"}, up_req_valid, 0);
        check({tag, "_up_req_offset"}, up_req_offset, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_cli_resp_valid"}, cli_resp_valid, 0);
    endtask

    task automatic stray_bytes(int n);
        for (int i = 0; i < n; i++) begin
            up_resp_valid = 1;
            up_resp_data  = 8'h55;
            tick();
        end
        up_resp_valid = 0;
    endtask

    // expects client c to win; upstream accepts after delay REQ cycles, then nbytes are streamed
    task automatic serve(int c, logic [31:0] off, int nbytes, int delay, bit noise, logic [7:0] seed);
        int n;
        logic [NCLI-1:0] oh;
        logic [7:0] d;
        oh = NCLI'(1) << c;
        ready_q.push_back({oh, off});
        n = 0;
        while (!up_req_valid && n < 50) begin
            tick();
            n++;
        end
        if (!up_req_valid) begin
            check("up_req_valid_wait", up_req_valid, 1);
            return;
        end
        check("grant", grant, oh);
        check("busy_req", busy, 1);
        cli_req_valid = cli_req_valid & ~cli_req_ready;
        for (int i = 0; i < delay; i++) begin
            if (noise) begin
                up_resp_valid = 1;
                up_resp_data  = 8'hee;
            end
            tick();
        end
        up_resp_valid = 0;
        up_req_ready  = 1;
        tick();
        check("up_req_valid_drop", up_req_valid, 0);
        if (!tied) up_req_ready = 0;
        for (int i = 0; i < nbytes; i++) begin
            d = seed + 8'(i);
            resp_q.push_back({oh, d});
            up_resp_valid = 1;
            up_resp_data  = d;
            if (i == RESP_LEN - 1) check("busy_before_last", busy, 1);
            tick();
        end
        up_resp_valid = 0;
        if (nbytes == RESP_LEN) begin
            check("busy_after_last", busy, 0);
            check("grant_released", grant, 0);
        end
    endtask

    initial begin
        logic [NCLI+31:0] r;
        logic [NCLI+7:0]  b;
        forever begin
            @(negedge clk);
            if (|cli_req_ready) begin
                if (ready_q.size() == 0) check("unexpected_ready", cli_req_ready, 0);
                else begin
                    r = ready_q.pop_front();
                    check("ready_onehot", cli_req_ready, r[NCLI+31:32]);
                    check("up_req_offset", up_req_offset, r[31:0]);
                end
            end
            if (|cli_resp_valid) begin
                if (resp_q.size() == 0) check("unexpected_strobe", cli_resp_valid, 0);
                else begin
                    b = resp_q.pop_front();
                    check("resp_route", cli_resp_valid, b[NCLI+7:8]);
                    check("resp_data", cli_resp_data, b[7:0]);
                end
            end
        end
    end

    initial begin
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 0;
        set_off(0, 32'h800);
        cli_req_valid = 2'b01;
        serve(0, 32'h800, 16, 3, 0, 8'h10);
        set_off(0, 32'h2000);
        set_off(1, 32'h1000);
        tick();
        cli_req_valid = 2'b11;
        serve(1, 32'h1000, 16, 1, 0, 8'h40);
        serve(0, 32'h2000, 16, 2, 0, 8'h80);
        tied = 1;
        up_req_ready = 1;
        set_off(0, 32'h4800);
        set_off(1, 32'h5000);
        cli_req_valid = 2'b11;
        serve(1, 32'h5000, 16, 0, 0, 8'hc0);
        serve(0, 32'h4800, 16, 0, 0, 8'h20);
        tied = 0;
        up_req_ready = 0;
        stray_bytes(3);
        set_off(0, 32'h6000);
        cli_req_valid = 2'b01;
        serve(0, 32'h6000, 16, 3, 1, 8'h30);
        set_off(1, 32'h3000);
        cli_req_valid = 2'b10;
        serve(1, 32'h3000, 5, 1, 0, 8'h70);
        repeat (99) tick();
        check("timeout_early", timeout_err, 0);
        check("busy_waiting", busy, 1);
        tick();
        check("timeout_err", timeout_err, 1);
        check("timeout_grant", grant, 0);
        check("timeout_busy", busy, 0);
        stray_bytes(3);
        set_off(0, 32'h7000);
        set_off(1, 32'h7800);
        cli_req_valid = 2'b11;
        serve(0, 32'h7000, 7, 1, 0, 8'ha0);
        rst = 1;
        cli_req_valid = '0;
        tick();
        check_reset_outputs("midrst");
        rst = 0;
        stray_bytes(3);
        cli_req_valid = 2'b11;
        serve(0, 32'h7000, 16, 1, 0, 8'h01);
        serve(1, 32'h7800, 16, 1, 0, 8'h90);
        repeat (3) tick();
        check("ready_q_empty", ready_q.size(), 0);
        check("resp_q_empty", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
